// File: rtl/reg_lock_scoreboard.sv
// rtl/reg_lock_scoreboard.sv - per-resource outstanding-write counters gating decode reads
// Allow flags and lock_ready look only at registered counters; lock/release/flush act at the edge.
module reg_lock_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int NSPEC = 3,
    parameter int NREL  = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4:0]            chk_rs,
    input  logic [4:0]            chk_rt,
    input  logic [NSPEC-1:0]      chk_spec,
    output logic                  rs_allow,
    output logic                  rt_allow,
    output logic                  spec_allow,
    input  logic                  lock_valid,
    input  logic [4:0]            lock_rd,
    input  logic [NSPEC-1:0]      lock_spec,
    output logic                  lock_ready,
    input  logic [NREL-1:0]       rel_valid,
    input  logic [NREL*5-1:0]     rel_rd,
    input  logic [NREL*NSPEC-1:0] rel_spec,
    input  logic                  flush,
    output logic                  busy,
    output logic                  err_underflow
);
    localparam int AW = 5;
    localparam int SW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] gpr_cnt  [NREG];
    logic [CNT_W-1:0] gpr_nxt  [NREG];
    logic [SW-1:0]    gpr_sum  [NREG];
    logic [SW-1:0]    gpr_dec  [NREG];
    logic [CNT_W-1:0] spec_cnt [NSPEC];
    logic [CNT_W-1:0] spec_nxt [NSPEC];
    logic [SW-1:0]    spec_sum [NSPEC];
    logic [SW-1:0]    spec_dec [NSPEC];
    logic [NSPEC-1:0] spec_nz;
    logic             lock_hit;
    logic             lock_fire;
    logic             uf_any;

    always_comb begin
        for (int s = 0; s < NSPEC; s++) begin
            spec_nz[s] = (spec_cnt[s] != '0);
        end
        rs_allow   = (chk_rs == '0) || (gpr_cnt[chk_rs] == '0);
        rt_allow   = (chk_rt == '0) || (gpr_cnt[chk_rt] == '0);
        spec_allow = ~|(chk_spec & spec_nz);
    end

    // Saturation check is independent of lock_valid so decode can see it before issuing.
    always_comb begin
        lock_hit = (lock_rd != '0) && (gpr_cnt[lock_rd] == CMAX);
        for (int s = 0; s < NSPEC; s++) begin
            if (lock_spec[s] && spec_cnt[s] == CMAX) lock_hit = 1'b1;
        end
        lock_ready = ~lock_hit;
        lock_fire  = lock_valid & lock_ready;
    end

    always_comb begin
        uf_any = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            gpr_dec[i] = '0;
            for (int p = 0; p < NREL; p++) begin
                if (i != 0 && rel_valid[p] && rel_rd[AW*p +: AW] == AW'(i))
                    gpr_dec[i] = gpr_dec[i] + SW'(1);
            end
            gpr_sum[i] = {2'b00, gpr_cnt[i]}
                       + SW'(lock_fire && i != 0 && lock_rd == AW'(i))
                       - gpr_dec[i];
            gpr_nxt[i] = gpr_sum[i][SW-1] ? '0 : gpr_sum[i][CNT_W-1:0];
            uf_any     = uf_any | gpr_sum[i][SW-1];
        end
        for (int s = 0; s < NSPEC; s++) begin
            spec_dec[s] = '0;
            for (int p = 0; p < NREL; p++) begin
                if (rel_valid[p] && rel_spec[NSPEC*p + s])
                    spec_dec[s] = spec_dec[s] + SW'(1);
            end
            spec_sum[s] = {2'b00, spec_cnt[s]} + SW'(lock_fire && lock_spec[s]) - spec_dec[s];
            spec_nxt[s] = spec_sum[s][SW-1] ? '0 : spec_sum[s][CNT_W-1:0];
            uf_any      = uf_any | spec_sum[s][SW-1];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NREG; i++)  busy = busy | (gpr_cnt[i] != '0);
        for (int s = 0; s < NSPEC; s++) busy = busy | (spec_cnt[s] != '0);
    end

    // Flush squashes that cycle's lock/release traffic, including any underflow it would raise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++)  gpr_cnt[i]  <= '0;
            for (int s = 0; s < NSPEC; s++) spec_cnt[s] <= '0;
            err_underflow <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++)  gpr_cnt[i]  <= '0;
            for (int s = 0; s < NSPEC; s++) spec_cnt[s] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)  gpr_cnt[i]  <= gpr_nxt[i];
            for (int s = 0; s < NSPEC; s++) spec_cnt[s] <= spec_nxt[s];
            if (uf_any) err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_lock_scoreboard.sv
// tb/tb_reg_lock_scoreboard.sv - directed scoreboard bench for reg_lock_scoreboard
module tb_reg_lock_scoreboard;
    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] chk_rs, chk_rt, lock_rd;
    logic [2:0] chk_spec, lock_spec;
    logic       rs_allow, rt_allow, spec_allow, lock_ready, busy, err_underflow;
    logic       lock_valid, flush;
    logic [1:0] rel_valid;
    logic [9:0] rel_rd;
    logic [5:0] rel_spec;

    int tests_run = 0;
    int tests_failed = 0;

    logic [5:0] exp_q[$];
    string      name_q[$];

    reg_lock_scoreboard dut (
        .clk(clk), .resetn(resetn),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_spec(chk_spec),
        .rs_allow(rs_allow), .rt_allow(rt_allow), .spec_allow(spec_allow),
        .lock_valid(lock_valid), .lock_rd(lock_rd), .lock_spec(lock_spec),
        .lock_ready(lock_ready),
        .rel_valid(rel_valid), .rel_rd(rel_rd), .rel_spec(rel_spec),
        .flush(flush), .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Expected vector order: {rs_allow, rt_allow, spec_allow, lock_ready, busy, err_underflow}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e, g;
            string      nm;
            string      fld [6];
            fld = '{"err_underflow", "busy", "lock_ready", "spec_allow", "rt_allow", "rs_allow"};
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {rs_allow, rt_allow, spec_allow, lock_ready, busy, err_underflow};
            for (int k = 0; k < 6; k++) begin
                tests_run++;
                if (g[k] !== e[k]) begin
                    tests_failed++;
                    $display("FAIL %s.%s got=%b exp=%b", nm, fld[k], g[k], e[k]);
                end
            end
        end
    end

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] cs,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] lsp,
                        input logic [1:0] rv, input logic [9:0] rrd, input logic [5:0] rsp,
                        input logic fl, input logic [5:0] exp_v, input string nm);
        chk_rs = rs; chk_rt = rt; chk_spec = cs;
        lock_valid = lv; lock_rd = lrd; lock_spec = lsp;
        rel_valid = rv; rel_rd = rrd; rel_spec = rsp; flush = fl;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        chk_rs = '0; chk_rt = '0; chk_spec = '0;
        lock_valid = 1'b0; lock_rd = '0; lock_spec = '0;
        rel_valid = '0; rel_rd = '0; rel_spec = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        step(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111100, "reset");
        // Index 0 never locks.
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'b111100, "r0_lock");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111100, "r0_after");

        // Lock rd8, release on port 1 three cycles later.
        step(8, 0, 0, 1, 8, 0, 0, 0, 0, 0, 6'b111100, "l8_c0");
        step(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b011110, "l8_c1");
        step(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b011110, "l8_c2");
        step(8, 0, 0, 0, 0, 0, 2'b10, {5'd8, 5'd0}, 0, 0, 6'b011110, "l8_rel");
        step(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111100, "l8_c4");

        // Saturate rd3 at 3, refused lock, lock+release while saturated, double release.
        step(3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 6'b111100, "sat_c0");
        step(3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 6'b011110, "sat_c1");
        step(3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 6'b011110, "sat_c2");
        step(3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 6'b011010, "sat_full");
        step(3, 0, 0, 1, 3, 0, 2'b01, 10'd3, 0, 0, 6'b011010, "sat_lockrel");
        step(3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 6'b011110, "sat_two");
        step(3, 0, 0, 0, 0, 0, 2'b11, {5'd3, 5'd3}, 0, 0, 6'b011110, "sat_dblrel");
        step(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111100, "sat_empty");

        // MULT-style lock of LO|HI, split release across both ports.
        step(0, 0, 3'b001, 1, 0, 3'b011, 0, 0, 0, 0, 6'b111100, "mult_lock");
        step(0, 0, 3'b001, 0, 0, 0, 2'b11, 0, 6'b010_001, 0, 6'b110110, "mult_rel");
        step(0, 0, 3'b011, 0, 0, 0, 0, 0, 0, 0, 6'b111100, "mult_done");

        // Flush drops rd4/CP0 and ignores a concurrent lock of rd9.
        step(4, 0, 3'b100, 1, 4, 3'b100, 0, 0, 0, 0, 6'b111100, "fl_lock");
        step(4, 9, 3'b100, 1, 9, 0, 0, 0, 0, 1, 6'b010110, "fl_flush");
        step(4, 9, 3'b100, 0, 0, 0, 0, 0, 0, 0, 6'b111100, "fl_after");

        // Underflow is sticky across flush.
        step(7, 0, 0, 0, 0, 0, 2'b01, 10'd7, 0, 0, 6'b111100, "uf_rel");
        step(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111101, "uf_set");
        step(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b111101, "uf_flush");
        step(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111101, "uf_hold");

        // Asynchronous reset: cleared by the next negedge, before any rising edge.
        resetn = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111100, "async_rst");
        resetn = 1'b1;

        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
